// File: rtl/axi_rd_id_remap_pkg.sv
// ---------------------------------------------------------------------------
// axi_rd_id_remap_pkg
// Shared definitions for the flat-port AXI read-ID remapper:
//   - AXI read response encodings
//   - cnt_width(): width of a per-entry outstanding-transaction counter
// The entry record itself depends on the ID and counter widths, so it is
// declared inside the table module from these helpers.
// ---------------------------------------------------------------------------
package axi_rd_id_remap_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Counter must hold 0..max_txns inclusive.
  function automatic int unsigned cnt_width(input int unsigned max_txns);
    int unsigned w;
    w = $clog2(max_txns + 32'd1);
    if (w < 32'd1) begin
      w = 32'd1;
    end else begin
      w = w;
    end
    return w;
  endfunction

endpackage

// File: rtl/axi_rd_id_remap_checker.sv
// ---------------------------------------------------------------------------
// axi_rd_id_remap_checker
// Protocol checks for the read-ID remapper.
// Ports:
//   clk, rst       : clock, synchronous active-high reset
//   r_last_fire    : R handshake with last=1 on the master side
//   r_entry_valid  : valid bit of the table entry addressed by the R ID
// ---------------------------------------------------------------------------
module axi_rd_id_remap_checker (
  input logic clk,
  input logic rst,
  input logic r_last_fire,
  input logic r_entry_valid
);

  // A closing R beat must always target an occupied table entry.
  a_r_last_on_valid_entry: assert property (
    @(posedge clk) disable iff (rst) r_last_fire |-> r_entry_valid
  );

endmodule

// File: rtl/axi_rd_id_remap_table.sv
// ---------------------------------------------------------------------------
// axi_rd_id_remap_table
// Remap table: per entry a valid bit, the stored slave ID and an outstanding
// read counter. Provides the combinational AR lookup (hit / lowest free
// entry) and the counter update for AR grants and R-last completions.
// Ports:
//   clk, rst       : clock, synchronous active-high reset
//   ar_id          : slave AR ID to look up
//   ar_fire        : AR handshake on the selected entry this cycle
//   ar_can         : an entry is selectable for ar_id
//   ar_idx         : selected entry (= master ID)
//   r_idx          : master R ID
//   r_last_fire    : R handshake with last=1
//   r_slv_id       : stored slave ID of entry r_idx
//   r_entry_valid  : valid bit of entry r_idx
//   busy           : registered OR of all valid bits
// ---------------------------------------------------------------------------
module axi_rd_id_remap_table
  import axi_rd_id_remap_pkg::*;
#(
  parameter int unsigned SLV_ID_WIDTH    = 8,
  parameter int unsigned MST_ID_WIDTH    = 2,
  parameter int unsigned MAX_TXNS_PER_ID = 4,
  parameter bit          SERIALIZE       = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [SLV_ID_WIDTH-1:0] ar_id,
  input  logic                    ar_fire,
  output logic                    ar_can,
  output logic [MST_ID_WIDTH-1:0] ar_idx,
  input  logic [MST_ID_WIDTH-1:0] r_idx,
  input  logic                    r_last_fire,
  output logic [SLV_ID_WIDTH-1:0] r_slv_id,
  output logic                    r_entry_valid,
  output logic                    busy
);

  localparam int unsigned NUM_IDS = 2 ** MST_ID_WIDTH;
  // Serialise mode restricts lookup and allocation to entry 0.
  localparam int unsigned USE_IDS = SERIALIZE ? 1 : NUM_IDS;
  localparam int unsigned CNT_W   = cnt_width(MAX_TXNS_PER_ID);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_TXNS_PER_ID);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef struct packed {
    logic                    valid;
    logic [SLV_ID_WIDTH-1:0] id;
    logic [CNT_W-1:0]        cnt;
  } entry_t;

  entry_t                tbl_r     [NUM_IDS];
  entry_t                tbl_nxt_s [NUM_IDS];
  logic                  busy_r;
  logic                  busy_nxt_s;
  logic [NUM_IDS-1:0]    hit_vec_s;
  logic [NUM_IDS-1:0]    free_vec_s;
  logic [NUM_IDS-1:0]    inc_vec_s;
  logic [NUM_IDS-1:0]    dec_vec_s;
  logic [MST_ID_WIDTH-1:0] hit_idx_s;
  logic [MST_ID_WIDTH-1:0] free_idx_s;

  // Lowest set bit index; scanning downwards leaves the lowest one last.
  function automatic logic [MST_ID_WIDTH-1:0] first_set(input logic [NUM_IDS-1:0] vec);
    logic [MST_ID_WIDTH-1:0] idx;
    idx = '0;
    for (int i = NUM_IDS - 1; i >= 0; i--) begin
      idx = vec[i] ? MST_ID_WIDTH'(i) : idx;
    end
    return idx;
  endfunction

  // Hit and free vectors over the usable part of the table.
  always_comb begin
    hit_vec_s  = '0;
    free_vec_s = '0;
    for (int i = 0; i < NUM_IDS; i++) begin
      hit_vec_s[i]  = (i < int'(USE_IDS)) && tbl_r[i].valid && (tbl_r[i].id == ar_id);
      free_vec_s[i] = (i < int'(USE_IDS)) && !tbl_r[i].valid;
    end
  end

  assign hit_idx_s  = first_set(hit_vec_s);
  assign free_idx_s = first_set(free_vec_s);

  // IDs are unique in the table, so at most one hit; a full hit stalls
  // rather than falling back to a free entry (that would split the ID).
  assign ar_can = (|hit_vec_s) ? (tbl_r[hit_idx_s].cnt < CNT_MAX) : (|free_vec_s);
  assign ar_idx = (|hit_vec_s) ? hit_idx_s : free_idx_s;

  assign r_slv_id      = tbl_r[r_idx].id;
  assign r_entry_valid = tbl_r[r_idx].valid;
  assign busy          = busy_r;

  // Per-entry next state: grant increments, R-last decrements, both cancel.
  always_comb begin
    busy_nxt_s = 1'b0;
    inc_vec_s  = '0;
    dec_vec_s  = '0;
    for (int i = 0; i < NUM_IDS; i++) begin
      tbl_nxt_s[i] = tbl_r[i];
      inc_vec_s[i] = ar_fire && (ar_idx == MST_ID_WIDTH'(i));
      // R-last on an empty entry is ignored so the counter cannot wrap.
      dec_vec_s[i] = r_last_fire && (r_idx == MST_ID_WIDTH'(i)) && tbl_r[i].valid;
      case ({inc_vec_s[i], dec_vec_s[i]})
        2'b10: begin
          tbl_nxt_s[i].valid = 1'b1;
          tbl_nxt_s[i].id    = ar_id;
          tbl_nxt_s[i].cnt   = tbl_r[i].cnt + CNT_ONE;
        end
        2'b01: begin
          tbl_nxt_s[i].cnt   = tbl_r[i].cnt - CNT_ONE;
          tbl_nxt_s[i].valid = (tbl_r[i].cnt != CNT_ONE);
        end
        default: begin
          tbl_nxt_s[i] = tbl_r[i];
        end
      endcase
      busy_nxt_s = busy_nxt_s | tbl_nxt_s[i].valid;
    end
  end

  // Table and busy flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_IDS; i++) begin
        tbl_r[i] <= '0;
      end
      busy_r <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_IDS; i++) begin
        tbl_r[i] <= tbl_nxt_s[i];
      end
      busy_r <= busy_nxt_s;
    end
  end

endmodule

// File: rtl/axi_rd_id_remap_flat.sv
// ---------------------------------------------------------------------------
// axi_rd_id_remap_flat
// Flat-port AXI read-path ID remapper: compresses SLV_ID_WIDTH slave IDs onto
// 2**MST_ID_WIDTH master IDs. AR and R are forwarded combinationally; the
// only state is the remap table.
// Ports:
//   clk_i, rst_i          : clock, synchronous active-high reset
//   slv_ar_*              : slave-side AR channel (wide ID)
//   slv_r_*               : slave-side R channel, ID restored from table
//   mst_ar_*              : master-side AR channel (remapped ID)
//   mst_r_*               : master-side R channel (narrow ID)
//   busy_o                : at least one table entry occupied
// ---------------------------------------------------------------------------
module axi_rd_id_remap_flat
  import axi_rd_id_remap_pkg::*;
#(
  parameter int unsigned SLV_ID_WIDTH    = 8,
  parameter int unsigned MST_ID_WIDTH    = 2,
  parameter int unsigned MAX_TXNS_PER_ID = 4,
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned DATA_WIDTH      = 64,
  parameter int unsigned AR_REST_WIDTH   = 29,
  parameter bit          SERIALIZE       = 1'b0
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [SLV_ID_WIDTH-1:0]  slv_ar_id_i,
  input  logic [ADDR_WIDTH-1:0]    slv_ar_addr_i,
  input  logic [7:0]               slv_ar_len_i,
  input  logic [AR_REST_WIDTH-1:0] slv_ar_rest_i,
  input  logic                     slv_ar_valid_i,
  output logic                     slv_ar_ready_o,
  output logic [SLV_ID_WIDTH-1:0]  slv_r_id_o,
  output logic [DATA_WIDTH-1:0]    slv_r_data_o,
  output logic [1:0]               slv_r_resp_o,
  output logic                     slv_r_last_o,
  output logic                     slv_r_valid_o,
  input  logic                     slv_r_ready_i,
  output logic [MST_ID_WIDTH-1:0]  mst_ar_id_o,
  output logic [ADDR_WIDTH-1:0]    mst_ar_addr_o,
  output logic [7:0]               mst_ar_len_o,
  output logic [AR_REST_WIDTH-1:0] mst_ar_rest_o,
  output logic                     mst_ar_valid_o,
  input  logic                     mst_ar_ready_i,
  input  logic [MST_ID_WIDTH-1:0]  mst_r_id_i,
  input  logic [DATA_WIDTH-1:0]    mst_r_data_i,
  input  logic [1:0]               mst_r_resp_i,
  input  logic                     mst_r_last_i,
  input  logic                     mst_r_valid_i,
  output logic                     mst_r_ready_o,
  output logic                     busy_o
);

  logic                    ar_can_s;
  logic                    ar_fire_s;
  logic [MST_ID_WIDTH-1:0] ar_idx_s;
  logic                    r_last_fire_s;
  logic                    r_entry_valid_s;

  // Gate both AR directions with the lookup result; ready never waits on
  // valid, so the master side sees no new ready-to-valid dependency.
  assign mst_ar_valid_o = slv_ar_valid_i & ar_can_s;
  assign slv_ar_ready_o = mst_ar_ready_i & ar_can_s;
  assign ar_fire_s      = slv_ar_valid_i & mst_ar_ready_i & ar_can_s;
  assign mst_ar_id_o    = ar_idx_s;
  assign mst_ar_addr_o  = slv_ar_addr_i;
  assign mst_ar_len_o   = slv_ar_len_i;
  assign mst_ar_rest_o  = slv_ar_rest_i;

  assign slv_r_data_o   = mst_r_data_i;
  assign slv_r_resp_o   = mst_r_resp_i;
  assign slv_r_last_o   = mst_r_last_i;
  assign slv_r_valid_o  = mst_r_valid_i;
  assign mst_r_ready_o  = slv_r_ready_i;
  assign r_last_fire_s  = mst_r_valid_i & slv_r_ready_i & mst_r_last_i;

  axi_rd_id_remap_table #(
    .SLV_ID_WIDTH    (SLV_ID_WIDTH),
    .MST_ID_WIDTH    (MST_ID_WIDTH),
    .MAX_TXNS_PER_ID (MAX_TXNS_PER_ID),
    .SERIALIZE       (SERIALIZE)
  ) u_table (
    .clk           (clk_i),
    .rst           (rst_i),
    .ar_id         (slv_ar_id_i),
    .ar_fire       (ar_fire_s),
    .ar_can        (ar_can_s),
    .ar_idx        (ar_idx_s),
    .r_idx         (mst_r_id_i),
    .r_last_fire   (r_last_fire_s),
    .r_slv_id      (slv_r_id_o),
    .r_entry_valid (r_entry_valid_s),
    .busy          (busy_o)
  );

  axi_rd_id_remap_checker u_checker (
    .clk           (clk_i),
    .rst           (rst_i),
    .r_last_fire   (r_last_fire_s),
    .r_entry_valid (r_entry_valid_s)
  );

endmodule

// File: tb/tb_axi_rd_id_remap_flat.sv
// ---------------------------------------------------------------------------
// tb_axi_rd_id_remap_flat
// Self-checking bench for axi_rd_id_remap_flat. Instance 0 uses the default
// parameters, instance 1 runs with SERIALIZE=1. Expected AR/R transfers are
// queued when driven and compared when the handshake appears at the DUT.
// ---------------------------------------------------------------------------
module tb_axi_rd_id_remap_flat;

  typedef struct {
    logic [1:0]  mid;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [28:0] rest;
  } ar_exp_t;

  typedef struct {
    logic [7:0]  sid;
    logic [63:0] data;
    logic [1:0]  resp;
    logic        last;
  } r_exp_t;

  logic        clk;
  logic        rst;
  logic [7:0]  ar_id      [2];
  logic [31:0] ar_addr    [2];
  logic [7:0]  ar_len     [2];
  logic [28:0] ar_rest    [2];
  logic        ar_valid   [2];
  logic        slv_ar_ready [2];
  logic [7:0]  slv_r_id   [2];
  logic [63:0] slv_r_data [2];
  logic [1:0]  slv_r_resp [2];
  logic        slv_r_last [2];
  logic        slv_r_valid [2];
  logic        slv_r_ready [2];
  logic [1:0]  mst_ar_id  [2];
  logic [31:0] mst_ar_addr [2];
  logic [7:0]  mst_ar_len [2];
  logic [28:0] mst_ar_rest [2];
  logic        mst_ar_valid [2];
  logic        mst_ar_ready [2];
  logic [1:0]  r_id       [2];
  logic [63:0] r_data     [2];
  logic [1:0]  r_resp     [2];
  logic        r_last     [2];
  logic        r_valid    [2];
  logic        mst_r_ready [2];
  logic        busy       [2];

  ar_exp_t exp_ar [2][$];
  r_exp_t  exp_r  [2][$];

  int checks   = 0;
  int failures = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    axi_rd_id_remap_flat #(
      .SERIALIZE (g == 1)
    ) dut (
      .clk_i          (clk),
      .rst_i          (rst),
      .slv_ar_id_i    (ar_id[g]),
      .slv_ar_addr_i  (ar_addr[g]),
      .slv_ar_len_i   (ar_len[g]),
      .slv_ar_rest_i  (ar_rest[g]),
      .slv_ar_valid_i (ar_valid[g]),
      .slv_ar_ready_o (slv_ar_ready[g]),
      .slv_r_id_o     (slv_r_id[g]),
      .slv_r_data_o   (slv_r_data[g]),
      .slv_r_resp_o   (slv_r_resp[g]),
      .slv_r_last_o   (slv_r_last[g]),
      .slv_r_valid_o  (slv_r_valid[g]),
      .slv_r_ready_i  (slv_r_ready[g]),
      .mst_ar_id_o    (mst_ar_id[g]),
      .mst_ar_addr_o  (mst_ar_addr[g]),
      .mst_ar_len_o   (mst_ar_len[g]),
      .mst_ar_rest_o  (mst_ar_rest[g]),
      .mst_ar_valid_o (mst_ar_valid[g]),
      .mst_ar_ready_i (mst_ar_ready[g]),
      .mst_r_id_i     (r_id[g]),
      .mst_r_data_i   (r_data[g]),
      .mst_r_resp_i   (r_resp[g]),
      .mst_r_last_i   (r_last[g]),
      .mst_r_valid_i  (r_valid[g]),
      .mst_r_ready_o  (mst_r_ready[g]),
      .busy_o         (busy[g])
    );
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Scoreboard: compare every AR/R handshake against the queued expectation.
  for (genvar g = 0; g < 2; g++) begin : g_mon
    always @(negedge clk) begin : mon
      ar_exp_t ea;
      r_exp_t  er;
      if (!rst && mst_ar_valid[g] && mst_ar_ready[g]) begin
        if (exp_ar[g].size() == 0) begin
          check_eq("ar_unexpected", 64'(exp_ar[g].size()), 64'd1);
        end else begin
          ea = exp_ar[g].pop_front();
          check_eq("ar_mst_id", 64'(mst_ar_id[g]), 64'(ea.mid));
          check_eq("ar_addr",   64'(mst_ar_addr[g]), 64'(ea.addr));
          check_eq("ar_len",    64'(mst_ar_len[g]), 64'(ea.len));
          check_eq("ar_rest",   64'(mst_ar_rest[g]), 64'(ea.rest));
        end
      end
      if (!rst && slv_r_valid[g] && slv_r_ready[g]) begin
        if (exp_r[g].size() == 0) begin
          check_eq("r_unexpected", 64'(exp_r[g].size()), 64'd1);
        end else begin
          er = exp_r[g].pop_front();
          check_eq("r_slv_id", 64'(slv_r_id[g]), 64'(er.sid));
          check_eq("r_data",   slv_r_data[g], er.data);
          check_eq("r_resp",   64'(slv_r_resp[g]), 64'(er.resp));
          check_eq("r_last",   64'(slv_r_last[g]), 64'(er.last));
          check_eq("r_ready",  64'(mst_r_ready[g]), 64'd1);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_ar(input int d, input logic [7:0] id, input logic [1:0] exp_mid);
    ar_exp_t e;
    ar_id[d]    = id;
    ar_addr[d]  = $urandom;
    ar_len[d]   = 8'($urandom_range(0, 15));
    ar_rest[d]  = 29'($urandom);
    ar_valid[d] = 1'b1;
    e.mid  = exp_mid;
    e.addr = ar_addr[d];
    e.len  = ar_len[d];
    e.rest = ar_rest[d];
    exp_ar[d].push_back(e);
  endtask

  task automatic wait_ar(input int d, input int max_cycles);
    bit done;
    done = 1'b0;
    for (int i = 0; i < max_cycles && !done; i++) begin
      @(negedge clk);
      done = slv_ar_ready[d] && mst_ar_valid[d];
    end
    check_eq("ar_grant_wait", 64'(done), 64'd1);
    tick();
    ar_valid[d] = 1'b0;
  endtask

  task automatic send_ar(input int d, input logic [7:0] id, input logic [1:0] exp_mid);
    start_ar(d, id, exp_mid);
    wait_ar(d, 20);
  endtask

  task automatic r_beat(input int d, input logic [1:0] mid, input logic last, input logic [7:0] sid);
    r_exp_t e;
    r_id[d]    = mid;
    r_last[d]  = last;
    r_data[d]  = {$urandom, $urandom};
    r_resp[d]  = 2'($urandom_range(0, 3));
    r_valid[d] = 1'b1;
    e.sid  = sid;
    e.data = r_data[d];
    e.resp = r_resp[d];
    e.last = last;
    exp_r[d].push_back(e);
  endtask

  task automatic send_r(input int d, input logic [1:0] mid, input int beats, input logic [7:0] sid);
    for (int b = 0; b < beats; b++) begin
      r_beat(d, mid, (b == beats - 1), sid);
      tick();
    end
    r_valid[d] = 1'b0;
  endtask

  // One cycle in which the pending AR must not be granted.
  task automatic stall_cycle(input int d, input string tag);
    @(negedge clk);
    check_eq(tag, 64'(slv_ar_ready[d]), 64'd0);
    check_eq(tag, 64'(mst_ar_valid[d]), 64'd0);
    tick();
  endtask

  task automatic check_busy(input int d, input string tag, input logic exp);
    @(negedge clk);
    check_eq(tag, 64'(busy[d]), 64'(exp));
    tick();
  endtask

  initial begin
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      ar_id[d] = 8'h00; ar_addr[d] = 32'h0; ar_len[d] = 8'h00; ar_rest[d] = 29'h0;
      ar_valid[d] = 1'b0; mst_ar_ready[d] = 1'b0; slv_r_ready[d] = 1'b0;
      r_id[d] = 2'd0; r_data[d] = 64'h0; r_resp[d] = 2'b00; r_last[d] = 1'b0; r_valid[d] = 1'b0;
    end
    repeat (3) tick();
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check_eq("rst_busy",         64'(busy[d]), 64'd0);
      check_eq("rst_mst_ar_valid", 64'(mst_ar_valid[d]), 64'd0);
      check_eq("rst_slv_r_valid",  64'(slv_r_valid[d]), 64'd0);
      check_eq("rst_slv_ar_ready", 64'(slv_ar_ready[d]), 64'd0);
    end
    tick();
    rst = 1'b0;
    for (int d = 0; d < 2; d++) begin
      mst_ar_ready[d] = 1'b1;
      slv_r_ready[d]  = 1'b1;
    end
    @(negedge clk);
    check_eq("idle_mst_ar_valid", 64'(mst_ar_valid[0]), 64'd0);
    check_eq("idle_busy",         64'(busy[0]), 64'd0);
    tick();

    // Single transaction round trip.
    send_ar(0, 8'h5A, 2'd0);
    check_busy(0, "busy_after_ar", 1'b1);
    send_r(0, 2'd0, 1, 8'h5A);
    check_busy(0, "busy_after_r", 1'b0);

    // Four distinct IDs fill the table; a fifth waits for entry 2 to drain.
    for (int k = 0; k < 4; k++) begin
      send_ar(0, 8'h10 + 8'(k), 2'(k));
    end
    start_ar(0, 8'h14, 2'd2);
    stall_cycle(0, "stall_table_full");
    stall_cycle(0, "stall_table_full");
    r_beat(0, 2'd2, 1'b1, 8'h12);
    stall_cycle(0, "stall_no_same_cycle_reuse");
    r_valid[0] = 1'b0;
    wait_ar(0, 1);

    // Four-beat burst on master ID 1: entry frees only on the last beat.
    start_ar(0, 8'h15, 2'd1);
    for (int b = 0; b < 4; b++) begin
      r_beat(0, 2'd1, (b == 3), 8'h11);
      stall_cycle(0, "stall_during_burst");
    end
    r_valid[0] = 1'b0;
    wait_ar(0, 1);
    send_r(0, 2'd0, 1, 8'h10);
    send_r(0, 2'd2, 1, 8'h14);
    send_r(0, 2'd3, 1, 8'h13);
    send_r(0, 2'd1, 1, 8'h15);
    check_busy(0, "busy_drained", 1'b0);

    // Same ID up to the per-entry limit, fifth waits for one completion.
    for (int k = 0; k < 4; k++) begin
      send_ar(0, 8'h33, 2'd0);
    end
    start_ar(0, 8'h33, 2'd0);
    stall_cycle(0, "stall_cnt_max");
    stall_cycle(0, "stall_cnt_max");
    r_beat(0, 2'd0, 1'b1, 8'h33);
    stall_cycle(0, "stall_cnt_max_r_cycle");
    r_valid[0] = 1'b0;
    wait_ar(0, 1);

    // Drain entry 0 to one outstanding, then grant and R-last together.
    for (int k = 0; k < 3; k++) begin
      send_r(0, 2'd0, 1, 8'h33);
    end
    start_ar(0, 8'h33, 2'd0);
    r_beat(0, 2'd0, 1'b1, 8'h33);
    @(negedge clk);
    check_eq("same_cycle_grant", 64'(slv_ar_ready[0]), 64'd1);
    tick();
    ar_valid[0] = 1'b0;
    r_valid[0]  = 1'b0;
    check_busy(0, "busy_same_cycle", 1'b1);
    send_ar(0, 8'h44, 2'd1);
    send_r(0, 2'd0, 1, 8'h33);
    send_ar(0, 8'h55, 2'd0);
    send_r(0, 2'd0, 1, 8'h55);
    send_r(0, 2'd1, 1, 8'h44);
    check_busy(0, "busy_drained2", 1'b0);

    // Serialise mode: a second ID waits until entry 0 drains completely.
    send_ar(1, 8'h01, 2'd0);
    send_ar(1, 8'h01, 2'd0);
    start_ar(1, 8'h02, 2'd0);
    stall_cycle(1, "ser_stall");
    r_beat(1, 2'd0, 1'b1, 8'h01);
    stall_cycle(1, "ser_stall_r1");
    r_valid[1] = 1'b0;
    stall_cycle(1, "ser_stall_one_left");
    r_beat(1, 2'd0, 1'b1, 8'h01);
    stall_cycle(1, "ser_stall_r2");
    r_valid[1] = 1'b0;
    wait_ar(1, 1);

    // Reset in the middle of a burst empties the table.
    r_beat(1, 2'd0, 1'b0, 8'h02);
    @(negedge clk);
    check_eq("ser_busy_mid_burst", 64'(busy[1]), 64'd1);
    tick();
    r_valid[1] = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check_eq("busy_after_mid_reset", 64'(busy[1]), 64'd0);
    check_eq("busy_after_reset0",    64'(busy[0]), 64'd0);
    tick();

    for (int d = 0; d < 2; d++) begin
      check_eq("ar_queue_empty", 64'(exp_ar[d].size()), 64'd0);
      check_eq("r_queue_empty",  64'(exp_r[d].size()), 64'd0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
